// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional divider datapath is built only when MULDIV_DIV_EN is defined.
//
// state | meaning
// IDLE  | waiting; also the one-cycle operand-latch slot after an accepted start
// CALC  | WIDTH iterations on operand magnitudes
// FIX   | sign correction, loads hi/lo
// DONE  | done pulse; a new start is accepted here
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic             r_pend;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_dz;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_signed, w_a_neg, w_b_neg, w_neg_res, w_accept;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

  assign w_signed  = ~r_op[0];
  assign w_a_neg   = w_signed & r_a[WIDTH-1];
  assign w_b_neg   = w_signed & r_b[WIDTH-1];
  assign w_neg_res = w_a_neg ^ w_b_neg;
  assign w_a_mag   = w_a_neg ? -r_a : r_a;
  assign w_b_mag   = w_b_neg ? -r_b : r_b;
  assign w_accept  = start & ~cancel & ~r_pend & ((r_state == S_IDLE) | (r_state == S_DONE));

  // Multiplier magnitude shifts out of lo while the product shifts in from the top
  assign w_sum      = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, w_a_mag} : '0);
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = w_neg_res ? -w_prod : w_prod;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, w_b_mag});
  assign w_diff  = w_shift[WIDTH-1:0] - w_b_mag;

  always_comb begin
    w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod_fix[WIDTH-1:0];
    if (r_op[1]) begin
      w_fix_hi = w_a_neg ? -r_acc_hi : r_acc_hi;
      w_fix_lo = w_neg_res ? -r_acc_lo : r_acc_lo;
    end
  end
`else
  assign w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_fix_lo = w_prod_fix[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pend   <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
      if (cancel) begin
        r_state <= S_IDLE;
        r_pend  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_pend) begin
              r_pend   <= 1'b0;
              r_acc_hi <= '0;
              r_cnt    <= CW'(WIDTH - 1);
              if (r_op[1]) begin
`ifdef MULDIV_DIV_EN
                if (r_b == '0) begin
                  r_hi    <= r_a;
                  r_lo    <= '1;
                  r_dz    <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_acc_lo <= w_a_mag;
                  r_state  <= S_CALC;
                end
`else
                r_hi    <= '0;
                r_lo    <= '0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
`endif
              end else begin
                r_acc_lo <= w_b_mag;
                r_state  <= S_CALC;
              end
            end else begin
              r_pend <= w_accept;
            end
          end
          S_CALC: begin
`ifdef MULDIV_DIV_EN
            if (r_op[1]) begin
              r_acc_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
            end else begin
              r_acc_hi <= w_sum[WIDTH:1];
              r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
            end
`else
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
`endif
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          S_FIX: begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
            r_pend  <= w_accept;
          end
        endcase
      end
    end
  end

  assign busy     = (r_state == S_CALC) | (r_state == S_FIX);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations
// checked against a plain-arithmetic reference model (follows MULDIV_DIV_EN like the DUT).
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cancel = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results from ordinary integer arithmetic, latency from the operation class
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el,
                       output logic edz, output int lat);
    logic [63:0] p;
    longint      q, r;
    edz = 1'b0;
    lat = W + 2;
    eh  = '0;
    el  = '0;
    if (o == 2'd0) begin
      p = 64'(longint'($signed(x)) * longint'($signed(y)));
      {eh, el} = p;
    end else if (o == 2'd1) begin
      p = 64'(x) * 64'(y);
      {eh, el} = p;
    end else begin
`ifdef MULDIV_DIV_EN
      if (y == '0) begin
        eh = x; el = '1; edz = 1'b1; lat = 1;
      end else begin
        if (o == 2'd2) begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
        end else begin
          q = longint'(x) / longint'(y);
          r = longint'(x) % longint'(y);
        end
        el = q[W-1:0];
        eh = r[W-1:0];
      end
`else
      lat = 1;
`endif
    end
  endtask

  // gap=0 issues start during the current (DONE) cycle, i.e. back-to-back
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int gap);
    logic [W-1:0] eh, el;
    logic         edz;
    int           lat;
    model(o, x, y, eh, el, edz, lat);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    chk("busy_at_k", {31'b0, busy}, 32'd0);
    chk("done_at_k", {31'b0, done}, 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      start = (c == 3 && lat > 4);
      chk($sformatf("done_k+%0d", c), {31'b0, done}, {31'b0, c == lat});
      chk($sformatf("busy_k+%0d", c), {31'b0, busy}, {31'b0, lat > 1 && c <= W + 1});
      chk($sformatf("dz_k+%0d", c), {31'b0, div_zero}, {31'b0, (c == lat) & edz});
    end
    start = 1'b0;
    chk($sformatf("hi op%0d %0h,%0h", o, x, y), hi, eh);
    chk($sformatf("lo op%0d %0h,%0h", o, x, y), lo, el);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;
    int           sel;

    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    do_op(2'd0, -32'sd3, 32'sd5, 1);
    do_op(2'd2, -32'sd7, 32'sd2, 0);
    do_op(2'd3, 32'd5, 32'd0, 1);
    do_op(2'd3, 32'd7, 32'd2, 0);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1);
    do_op(2'd2, 32'hFFFFFFF9, 32'd0, 0);

    // cancel in the 10th CALC cycle alongside start
    do_op(2'd1, 32'd2, 32'd3, 1);
    @(negedge clk); @(negedge clk);
    start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_cancel", {31'b0, busy}, 32'd1);
    cancel = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    chk("busy_after_cancel", {31'b0, busy}, 32'd0);
    quiet("no_done_after_cancel", W + 6);
    chk("hi_kept_cancel", hi, 32'd0);
    chk("lo_kept_cancel", lo, 32'd6);
    do_op(2'd3, 32'd7, 32'd2, 0);

    // cancel and start together in DONE: cancel wins
    @(negedge clk);
    cancel = 1'b1; start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    quiet("cancel_beats_start", W + 6);

    // asynchronous reset between edges mid-CALC
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    @(negedge clk); @(negedge clk);
    start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    quiet("no_done_after_rst", W + 6);
    do_op(2'd1, 32'd4, 32'd4, 0);

    for (int i = 0; i < 16; i++) begin
      ro  = 2'($urandom_range(0, 3));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = '0;
      else if (sel == 1) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
      else if (sel == 2) ry = 32'($urandom_range(1, 15));
      do_op(ro, rx, ry, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter, SHALL exist: WIDTH, 32, operand width; hi/lo outputs are WIDTH bits each.
REQ-002 Ports SHALL be, clock and reset first:
  clk      input   1      single clock, rising-edge.
  rst      input   1      asynchronous, active-high reset.
  start    input   1      request a new operation.
  op       input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
  a        input   WIDTH  multiplicand / dividend.
  b        input   WIDTH  multiplier / divisor.
  cancel   input   1      pipeline flush; abort in-flight operation.
  busy     output  1      high in CALC and FIX.
  done     output  1      one-cycle pulse; hi/lo newly valid.
  hi       output  WIDTH  product upper half / remainder.
  lo       output  WIDTH  product lower half / quotient.
  div_zero output  1      high with done when divisor was zero.
REQ-003 Clocking and reset SHALL be one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-005 start SHALL be accepted only in IDLE or DONE; a, b, op latched at that edge; later input changes ignored.
REQ-006 Accepted start at edge k SHALL go to CALC for WIDTH cycles, FIX 1 cycle, DONE 1 cycle; done=1 in the cycle beginning at edge k+WIDTH+2.
REQ-007 start while busy SHALL be ignored and not queued.
REQ-008 start in DONE SHALL be accepted; done still pulses that cycle; next state CALC (back-to-back).
REQ-009 Multiply SHALL be iterative shift-add on operand magnitudes, one bit per CALC cycle; signed (MULT) product negated in FIX when operand signs differ; 2*WIDTH-bit result {hi,lo}.
REQ-010 Divide SHALL be iterative restoring division on magnitudes, one quotient bit per CALC cycle; DIV quotient negated when signs differ, remainder takes sign of dividend.
REQ-011 DIV of most-negative by -1 SHALL yield lo=most-negative, hi=0, no flag.
REQ-012 DIV/DIVU with b==0 SHALL skip CALC/FIX: DONE at edge k+1, hi=a, lo=all-ones, div_zero=1.
REQ-013 hi/lo SHALL update only on entry to DONE and hold until the next DONE.
REQ-014 div_zero SHALL be asserted only while done=1.
REQ-015 cancel=1 at any edge SHALL force IDLE next; no done; hi/lo unchanged; cancel wins over simultaneous start.
REQ-016 busy SHALL be combinational from state: busy=1 in CALC and FIX only.

Reset
REQ-017 rst=1 SHALL immediately force IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, including mid-CALC.
REQ-018 After rst release the first start SHALL follow REQ-006 timing exactly.

Configuration
REQ-019 Macro MULDIV_DIV_EN SHALL gate the divider datapath.
REQ-020 Defined: full behaviour of REQ-010..REQ-012.
REQ-021 Undefined: no divider logic; DIV/DIVU go to DONE at edge k+1 with hi=0, lo=0, div_zero=0; multiply unchanged.

Verification (WIDTH=32, MULDIV_DIV_EN defined unless stated)
REQ-022 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at k+34, hi=0xFFFFFFFE, lo=0x00000001, busy high k+1..k+33.
REQ-023 MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=-7 b=2 started in DONE -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-024 DIVU a=5 b=0 -> done at k+1, hi=5, lo=0xFFFFFFFF, div_zero=1; MULDIV_DIV_EN undefined, DIVU 7/2 -> done at k+1, hi=lo=0.
REQ-025 MULTU 2*3 then cancel in 10th CALC cycle with start=1 -> IDLE next edge, no done, hi/lo keep prior values; new DIVU 7/2 -> lo=3, hi=1.
REQ-026 rst pulse mid-CALC (async, between edges) -> outputs zero immediately, no done; subsequent MULTU 4*4 -> lo=16 at k+34.
